// File: rtl/fetch_pc_stage.sv
// IF stage: PC register, imem request and IF/ID register; one instruction per cycle, 1-cycle IF/ID latency.
// Backpressure: hazard freezes PC and IF/ID; imem_ready=0 inserts bubbles; a taken branch costs one bubble.
module fetch_pc_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        hazard,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        branch_misalign
);

    typedef enum logic {BOOT, RUN} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_pc4_q, if_id_pc4_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic        branch_misalign_q, branch_misalign_d;

    always_comb begin
        state_d           = state_q;
        pc_d              = pc_q;
        if_id_pc_d        = if_id_pc_q;
        if_id_pc4_d       = if_id_pc4_q;
        if_id_instr_d     = if_id_instr_q;
        if_id_valid_d     = if_id_valid_q;
        branch_misalign_d = 1'b0;
        if (state_q == BOOT) begin
            state_d = RUN;
        end else if (branch_taken) begin
            // Redirect wins over everything; the in-flight sequential fetch is dropped.
            pc_d              = {branch_target[31:2], 2'b00};
            if_id_instr_d     = NOP_INSTR;
            if_id_valid_d     = 1'b0;
            branch_misalign_d = |branch_target[1:0];
        end else if (hazard) begin
            pc_d = pc_q;
        end else if (imem_ready) begin
            if_id_pc_d    = pc_q;
            if_id_pc4_d   = pc_q + 32'd4;
            if_id_instr_d = imem_rdata;
            if_id_valid_d = 1'b1;
            pc_d          = pc_q + 32'd4;
        end else begin
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q           <= BOOT;
            pc_q              <= RESET_PC;
            if_id_pc_q        <= 32'd0;
            if_id_pc4_q       <= 32'd0;
            if_id_instr_q     <= NOP_INSTR;
            if_id_valid_q     <= 1'b0;
            branch_misalign_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            pc_q              <= pc_d;
            if_id_pc_q        <= if_id_pc_d;
            if_id_pc4_q       <= if_id_pc4_d;
            if_id_instr_q     <= if_id_instr_d;
            if_id_valid_q     <= if_id_valid_d;
            branch_misalign_q <= branch_misalign_d;
        end
    end

    assign imem_req        = (state_q == RUN);
    assign imem_addr       = pc_q;
    assign if_id_pc        = if_id_pc_q;
    assign if_id_pc4       = if_id_pc4_q;
    assign if_id_instr     = if_id_instr_q;
    assign if_id_valid     = if_id_valid_q;
    assign branch_misalign = branch_misalign_q;

endmodule
